// File: rtl/booth_job_scheduler.sv
// rtl/booth_job_scheduler.sv - operand FIFO and start/done sequencer for booth_multiplier
//
// Queues signed operand pairs, issues them one at a time to the multiplier
// with a one-cycle start pulse, waits for done and hands the product out on a
// registered valid/ready port. Jobs whose done never arrives within TIMEOUT
// wait cycles are dropped and flagged in the sticky timeout_err.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_x/in_y     operand pair input handshake
//   mul_start/mul_x/mul_y           start pulse and held operands to multiplier
//   mul_done/mul_result             done level and product from multiplier
//   out_valid/out_ready/out_result  product output handshake
//   fifo_count                      operand FIFO occupancy
//   busy                            sequencer not idle
//   timeout_err                     sticky job-abandoned flag
//   job_count                       captured-product counter (BOOTH_SCHED_STATS_EN only)
//
// Build option: define BOOTH_SCHED_STATS_EN to add the job_count output.

module booth_job_scheduler #(
    parameter int X_W     = 4,
    parameter int Y_W     = 6,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [X_W-1:0]             in_x,
    input  logic [Y_W-1:0]             in_y,
    output logic                       mul_start,
    output logic [X_W-1:0]             mul_x,
    output logic [Y_W-1:0]             mul_y,
    input  logic                       mul_done,
    input  logic [X_W+Y_W-1:0]         mul_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [X_W+Y_W-1:0]         out_result,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy,
    output logic                       timeout_err
`ifdef BOOTH_SCHED_STATS_EN
    ,
    output logic [15:0]                job_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int R_W   = X_W + Y_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [R_W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               mul_start_q, mul_start_d;
    logic [X_W-1:0]     mul_x_q, mul_x_d;
    logic [Y_W-1:0]     mul_y_q, mul_y_d;
    logic               out_valid_q, out_valid_d;
    logic [R_W-1:0]     out_result_q, out_result_d;
    logic               timeout_err_q, timeout_err_d;
    logic               push;
    logic               pop;
    logic               capture;
    logic [R_W-1:0]     head;

    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        mul_start_d   = 1'b0;
        mul_x_d       = mul_x_q;
        mul_y_d       = mul_y_q;
        out_valid_d   = out_valid_q && !out_ready;
        out_result_d  = out_result_q;
        timeout_err_d = timeout_err_q;
        capture       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    mul_x_d     = head[R_W-1:Y_W];
                    mul_y_d     = head[Y_W-1:0];
                    mul_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // done may still be high from the previous job; it is not looked at here
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    // a blocked output freezes the timer: the multiplier holds its result
                    if (!out_valid_q || out_ready) begin
                        capture      = 1'b1;
                        out_valid_d  = 1'b1;
                        out_result_d = mul_result;
                        state_d      = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_x, in_y};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            mul_start_q   <= 1'b0;
            mul_x_q       <= '0;
            mul_y_q       <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            mul_start_q   <= mul_start_d;
            mul_x_q       <= mul_x_d;
            mul_y_q       <= mul_y_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef BOOTH_SCHED_STATS_EN
    logic [15:0] job_count_q, job_count_d;

    assign job_count_d = capture ? job_count_q + 16'd1 : job_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_count_q <= '0;
        end else begin
            job_count_q <= job_count_d;
        end
    end

    assign job_count = job_count_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

    assign mul_start   = mul_start_q;
    assign mul_x       = mul_x_q;
    assign mul_y       = mul_y_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign fifo_count  = count_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_booth_job_scheduler.sv
// tb/tb_booth_job_scheduler.sv - scoreboard bench for booth_job_scheduler

module tb_booth_job_scheduler;

    localparam int K = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_x = '0;
    logic [5:0]  in_y = '0;
    logic        mul_start;
    logic [3:0]  mul_x;
    logic [5:0]  mul_y;
    logic        mul_done;
    logic [9:0]  mul_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_result;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        timeout_err;
`ifdef BOOTH_SCHED_STATS_EN
    logic [15:0] job_count;
`endif

    booth_job_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .mul_start  (mul_start),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .fifo_count (fifo_count),
        .busy       (busy),
        .timeout_err(timeout_err)
`ifdef BOOTH_SCHED_STATS_EN
        ,
        .job_count  (job_count)
`endif
    );

    always #5 clk = ~clk;

    // Hand-computed operand pairs and 10-bit two's complement products
    localparam logic [3:0] VX [10] = '{4'h5, 4'h8, 4'h7, 4'h8, 4'hF, 4'h3, 4'h0, 4'h6, 4'hD, 4'h7};
    localparam logic [5:0] VY [10] = '{6'h23, 6'h1F, 6'h20, 6'h20, 6'h3F, 6'h0A, 6'h3B, 6'h39, 6'h14, 6'h1F};
    localparam logic [9:0] VP [10] = '{10'h36F, 10'h308, 10'h320, 10'h100, 10'h001,
                                        10'h01E, 10'h000, 10'h3D6, 10'h3C4, 10'h0D9};

    // Behavioural multiplier: done K cycles after start, held until the next start
    logic       mdl_done;
    logic [9:0] mdl_prod;
    int         mdl_cnt;
    logic       never_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_done <= 1'b0;
            mdl_prod <= '0;
            mdl_cnt  <= 0;
        end else if (mul_start) begin
            mdl_prod <= {{6{mul_x[3]}}, mul_x} * {{4{mul_y[5]}}, mul_y};
            mdl_cnt  <= K;
            mdl_done <= 1'b0;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1 && !never_done) mdl_done <= 1'b1;
        end
    end

    assign mul_done   = mdl_done;
    assign mul_result = mdl_prod;

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %0h expected none", out_result);
            end else begin
                check("out_result", {22'd0, out_result}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int idx, input logic exp_ready, input logic want);
        in_valid = 1'b1;
        in_x     = VX[idx];
        in_y     = VY[idx];
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        if (exp_ready && want) exp_q.push_back(VP[idx]);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || busy || fifo_count != 0 || out_valid) && n < max) begin
            tick();
            n++;
        end
        check(name, {31'd0, (exp_q.size() != 0 || busy || fifo_count != 0 || out_valid)}, 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},    {31'd0, in_ready},    32'd1);
        check({tag, "_mul_start"},   {31'd0, mul_start},   32'd0);
        check({tag, "_mul_x"},       {28'd0, mul_x},       32'd0);
        check({tag, "_mul_y"},       {26'd0, mul_y},       32'd0);
        check({tag, "_out_valid"},   {31'd0, out_valid},   32'd0);
        check({tag, "_out_result"},  {22'd0, out_result},  32'd0);
        check({tag, "_fifo_count"},  {29'd0, fifo_count},  32'd0);
        check({tag, "_busy"},        {31'd0, busy},        32'd0);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
`ifdef BOOTH_SCHED_STATS_EN
        check({tag, "_job_count"},   {16'd0, job_count},   32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // Single job: start two edges after the push, product -145
        out_ready = 1'b1;
        push(0, 1'b1, 1'b1);
        check("single_start_e0", {31'd0, mul_start}, 32'd0);
        tick();
        check("single_start_e1", {31'd0, mul_start}, 32'd1);
        check("single_busy",     {31'd0, busy},      32'd1);
        check("single_mul_x",    {28'd0, mul_x},     32'h5);
        check("single_mul_y",    {26'd0, mul_y},     32'h23);
        tick();
        check("single_start_e2", {31'd0, mul_start}, 32'd0);
        drain("single_drain", 100);
        check("single_busy_end", {31'd0, busy}, 32'd0);

        // FIFO full: the sixth back-to-back pair is refused
        out_ready = 1'b0;
        push(1, 1'b1, 1'b1);
        push(2, 1'b1, 1'b1);
        push(3, 1'b1, 1'b1);
        push(4, 1'b1, 1'b1);
        push(5, 1'b1, 1'b1);
        push(6, 1'b0, 1'b1);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        repeat (30) tick();
        check("full_count_stall", {29'd0, fifo_count}, 32'd3);
        out_ready = 1'b1;
        drain("full_drain", 300);

        // Output backpressure: second job holds in WAIT, no timeout
        out_ready = 1'b0;
        push(7, 1'b1, 1'b1);
        push(8, 1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        repeat (70) tick();
        check("bp_mul_x",       {28'd0, mul_x},       {28'd0, VX[8]});
        check("bp_mul_y",       {26'd0, mul_y},       {26'd0, VY[8]});
        check("bp_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("bp_busy",        {31'd0, busy},        32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_second_valid",  {31'd0, out_valid},  32'd1);
        check("bp_second_result", {22'd0, out_result}, {22'd0, VP[8]});
        drain("bp_drain", 100);

        // Stale done through the ISSUE cycle must not be captured
        push(9, 1'b1, 1'b1);
        push(4, 1'b1, 1'b1);
        n = 0;
        while (!(mul_start && mul_y == VY[4]) && n < 100) begin
            tick();
            n++;
        end
        check("stale_issue_seen", {31'd0, mul_start}, 32'd1);
        tick();
        check("stale_no_capture", {31'd0, out_valid}, 32'd0);
        drain("stale_drain", 100);

        // Timeout: done never comes, job dropped after 64 WAIT cycles
        never_done = 1'b1;
        check("to_err_before", {31'd0, timeout_err}, 32'd0);
        push(6, 1'b1, 1'b0);
        push(1, 1'b1, 1'b1);
        n = 0;
        while (!mul_start && n < 20) begin
            tick();
            n++;
        end
        check("to_issue_seen", {31'd0, mul_start}, 32'd1);
        tick();
        repeat (63) tick();
        check("to_err_63", {31'd0, timeout_err}, 32'd0);
        tick();
        check("to_err_64",     {31'd0, timeout_err}, 32'd1);
        check("to_no_valid",   {31'd0, out_valid},   32'd0);
        never_done = 1'b0;
        drain("to_next_drain", 100);
        check("to_err_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset in WAIT with three jobs queued
        out_ready = 1'b0;
        push(0, 1'b1, 1'b0);
        push(1, 1'b1, 1'b0);
        push(2, 1'b1, 1'b0);
        push(3, 1'b1, 1'b0);
        check("rst_pre_count", {29'd0, fifo_count}, 32'd3);
        check("rst_pre_busy",  {31'd0, busy},       32'd1);
`ifdef BOOTH_SCHED_STATS_EN
        check("rst_pre_jobs",  {16'd0, job_count},  32'd11);
`endif
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        rst_n = 1'b1;
        tick();

        // Recovery after reset
        out_ready = 1'b1;
        push(5, 1'b1, 1'b1);
        drain("recover_drain", 100);
`ifdef BOOTH_SCHED_STATS_EN
        check("recover_jobs", {16'd0, job_count}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
